// File: rtl/demux4x9_tdm_pkg.sv
// Shared definitions for the 4-channel, 9-bit TDM demultiplexer.
//   W_DEF     default sample width
//   NCH       number of output channels
//   SLOT_W    width of the slot counter and channel index
//   LOCKN_DEF default number of aligned SYNCs needed for LOCK
//   sat_inc   saturating increment used by the lock counter
package demux4x9_tdm_pkg;

    localparam int W_DEF     = 9;
    localparam int NCH       = 4;
    localparam int SLOT_W    = 2;
    localparam int LOCKN_DEF = 2;

    // Increment v by one, never going past lim.
    function automatic logic [SLOT_W-1:0] sat_inc(input logic [SLOT_W-1:0] v,
                                                  input logic [SLOT_W-1:0] lim);
        logic [SLOT_W-1:0] r;
        if (v >= lim) begin
            r = lim;
        end else begin
            r = v + 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/demux4x9_tdm_demux_chan.sv
// One output channel of the demultiplexer: holding register, data-ready flag
// and sticky overrun flag.
//   clk_i  system clock
//   rstn_i asynchronous active-low reset
//   wr_i   write strobe for this channel
//   ack_i  consumer acknowledge, clears rdy_o unless a write lands the same cycle
//   din_i  sample to capture
//   y_o    holding register
//   rdy_o  data-ready flag
//   ovf_o  sticky overrun flag (cleared only by reset)
module demux_chan
    import demux4x9_tdm_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         wr_i,
    input  logic         ack_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] y_o,
    output logic         rdy_o,
    output logic         ovf_o
);

    logic [W-1:0] y_q, y_d;
    logic         rdy_q, rdy_d;
    logic         ovf_q, ovf_d;

    // Next-state: a write beats a simultaneous acknowledge; overrun only when
    // unread data is overwritten without an acknowledge in the same cycle.
    always_comb begin
        y_d   = y_q;
        rdy_d = rdy_q;
        ovf_d = ovf_q;
        if (wr_i) begin
            y_d   = din_i;
            rdy_d = 1'b1;
            if (rdy_q && !ack_i) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end else if (ack_i) begin
            rdy_d = 1'b0;
        end else begin
            rdy_d = rdy_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            y_q   <= '0;
            rdy_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            rdy_q <= rdy_d;
            ovf_q <= ovf_d;
        end
    end

    assign y_o   = y_q;
    assign rdy_o = rdy_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/demux4x9_tdm.sv
// 1-to-4 demultiplexer for a time-division sample stream. In AUTO mode the
// destination follows a slot counter aligned by frame SYNC; otherwise SEL
// picks the channel directly.
//   clk_i         system clock
//   rstn_i        asynchronous active-low reset
//   din_i/dv_i    input sample and its valid strobe
//   sync_i        (with dv_i) marks slot 0
//   auto_i        1 = slot-counter routing, 0 = SEL routing
//   sel_i         destination channel in SEL mode
//   ack_i         per-channel acknowledge
//   y0_o..y3_o    channel holding registers
//   rdy_o/ovf_o   per-channel ready and sticky overrun flags
//   frm_o         pulse: slot-3 sample written in AUTO mode
//   serr_o        pulse: SYNC arrived off slot 0
//   lock_o        frame alignment established
module demux4x9_tdm
    import demux4x9_tdm_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LOCKN = LOCKN_DEF
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [W-1:0]      din_i,
    input  logic              dv_i,
    input  logic              sync_i,
    input  logic              auto_i,
    input  logic [SLOT_W-1:0] sel_i,
    input  logic [NCH-1:0]    ack_i,
    output logic [W-1:0]      y0_o,
    output logic [W-1:0]      y1_o,
    output logic [W-1:0]      y2_o,
    output logic [W-1:0]      y3_o,
    output logic [NCH-1:0]    rdy_o,
    output logic [NCH-1:0]    ovf_o,
    output logic              frm_o,
    output logic              serr_o,
    output logic              lock_o
);

    localparam logic [SLOT_W-1:0] LOCKN_C = SLOT_W'(LOCKN);

    logic [SLOT_W-1:0] dest_s;
    logic [NCH-1:0]    wr_s;
    logic [W-1:0]      y_s [NCH];

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [SLOT_W-1:0] cnt_q,  cnt_d;
    logic              lock_q, lock_d;
    logic              serr_q, serr_d;
    logic              frm_q,  frm_d;

    // Destination decode and one-hot write strobes.
    always_comb begin
        if (auto_i) begin
            if (sync_i) begin
                dest_s = 2'd0;
            end else begin
                dest_s = slot_q;
            end
        end else begin
            dest_s = sel_i;
        end
        wr_s = '0;
        if (dv_i) begin
            wr_s[dest_s] = 1'b1;
        end else begin
            wr_s = '0;
        end
    end

    // Slot counter, lock tracking and the FRM/SERR pulses; SEL mode holds
    // all framing state.
    always_comb begin
        slot_d = slot_q;
        cnt_d  = cnt_q;
        lock_d = lock_q;
        serr_d = 1'b0;
        frm_d  = 1'b0;
        if (auto_i && dv_i) begin
            // A misplaced SYNC routes to slot 0, so dest+1 also realigns to 1.
            slot_d = dest_s + 2'd1;
            frm_d  = (dest_s == 2'd3);
            if (sync_i && (slot_q != 2'd0)) begin
                serr_d = 1'b1;
                lock_d = 1'b0;
                cnt_d  = 2'd0;
            end else if (sync_i) begin
                cnt_d = sat_inc(cnt_q, LOCKN_C);
                if (sat_inc(cnt_q, LOCKN_C) == LOCKN_C) begin
                    lock_d = 1'b1;
                end else begin
                    lock_d = lock_q;
                end
            end else begin
                cnt_d  = cnt_q;
                lock_d = lock_q;
            end
        end else begin
            slot_d = slot_q;
        end
    end

    // Framing state registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            slot_q <= 2'd0;
            cnt_q  <= 2'd0;
            lock_q <= 1'b0;
            serr_q <= 1'b0;
            frm_q  <= 1'b0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
            serr_q <= serr_d;
            frm_q  <= frm_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        demux_chan #(.W(W)) u_chan (
            .clk_i (clk_i),
            .rstn_i(rstn_i),
            .wr_i  (wr_s[k]),
            .ack_i (ack_i[k]),
            .din_i (din_i),
            .y_o   (y_s[k]),
            .rdy_o (rdy_o[k]),
            .ovf_o (ovf_o[k])
        );
    end

    assign y0_o   = y_s[0];
    assign y1_o   = y_s[1];
    assign y2_o   = y_s[2];
    assign y3_o   = y_s[3];
    assign frm_o  = frm_q;
    assign serr_o = serr_q;
    assign lock_o = lock_q;

endmodule

// File: tb/tb_demux4x9_tdm.sv
// Self-checking bench for demux4x9_tdm: a behavioural model compared every
// cycle, plus hand-computed expectations at the interesting points.
module tb_demux4x9_tdm;

    localparam int LOCKN = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [8:0] din = 9'd0;
    logic       dv = 1'b0;
    logic       sync = 1'b0;
    logic       auto_m = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [3:0] ack = 4'd0;
    logic [8:0] y0, y1, y2, y3;
    logic [3:0] rdy, ovf;
    logic       frm, serr, lock;

    int checks = 0;
    int failures = 0;

    demux4x9_tdm #(.W(9), .LOCKN(LOCKN)) dut (
        .clk_i (clk),   .rstn_i(rstn),
        .din_i (din),   .dv_i  (dv),    .sync_i(sync),
        .auto_i(auto_m), .sel_i(sel),   .ack_i (ack),
        .y0_o  (y0),    .y1_o  (y1),    .y2_o  (y2),   .y3_o(y3),
        .rdy_o (rdy),   .ovf_o (ovf),
        .frm_o (frm),   .serr_o(serr),  .lock_o(lock)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][8:0] y;
        logic [3:0]      rdy;
        logic [3:0]      ovf;
        int              slot;
        int              cnt;
        logic            lock;
        logic            serr;
        logic            frm;
    } model_t;

    model_t m;

    function automatic model_t step_model(input model_t c, input logic [8:0] d_in,
                                          input logic v, s, a, input logic [1:0] sl,
                                          input logic [3:0] ak);
        model_t n = c;
        int d;
        d = a ? (s ? 0 : c.slot) : int'(sl);
        n.serr = 1'b0;
        n.frm  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (v && k == d) begin
                if (c.rdy[k] && !ak[k]) n.ovf[k] = 1'b1;
                n.y[k]   = d_in;
                n.rdy[k] = 1'b1;
            end else if (ak[k]) begin
                n.rdy[k] = 1'b0;
            end
        end
        if (v && a) begin
            if (s && c.slot != 0) begin
                n.serr = 1'b1;
                n.lock = 1'b0;
                n.cnt  = 0;
            end else if (s) begin
                n.cnt = (c.cnt + 1 > LOCKN) ? LOCKN : c.cnt + 1;
                if (n.cnt == LOCKN) n.lock = 1'b1;
            end
            n.slot = (d + 1) % 4;
            n.frm  = (d == 3);
        end
        return n;
    endfunction

    // Reference model state, cleared by the same asynchronous reset.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) m <= '0;
        else       m <= step_model(m, din, dv, sync, auto_m, sel, ack);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rstn) begin
            chk("m_y0", 32'(y0), 32'(m.y[0]));
            chk("m_y1", 32'(y1), 32'(m.y[1]));
            chk("m_y2", 32'(y2), 32'(m.y[2]));
            chk("m_y3", 32'(y3), 32'(m.y[3]));
            chk("m_rdy", 32'(rdy), 32'(m.rdy));
            chk("m_ovf", 32'(ovf), 32'(m.ovf));
            chk("m_frm", 32'(frm), 32'(m.frm));
            chk("m_serr", 32'(serr), 32'(m.serr));
            chk("m_lock", 32'(lock), 32'(m.lock));
        end
    end

    // Apply one input vector across one rising edge; returns 2 ns after it.
    task automatic cyc(input logic [8:0] d_in, input logic v, s, a,
                       input logic [1:0] sl, input logic [3:0] ak);
        din = d_in; dv = v; sync = s; auto_m = a; sel = sl; ack = ak;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_y0", 32'(y0), 32'h0);
        chk("rst_rdy", 32'(rdy), 32'h0);
        chk("rst_lock", 32'(lock), 32'h0);
        rstn = 1'b1;

        // Frame 1 in AUTO mode, SYNC on the first sample.
        cyc(9'h101, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0000);
        chk("t1_y0", 32'(y0), 32'h101);
        chk("t1_rdy0", 32'(rdy), 32'b0001);
        cyc(9'h102, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000);
        cyc(9'h103, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000);
        chk("t1_frm_early", 32'(frm), 32'h0);
        cyc(9'h104, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000);
        chk("t1_y1", 32'(y1), 32'h102);
        chk("t1_y2", 32'(y2), 32'h103);
        chk("t1_y3", 32'(y3), 32'h104);
        chk("t1_rdy", 32'(rdy), 32'b1111);
        chk("t1_frm", 32'(frm), 32'h1);
        chk("t1_ovf", 32'(ovf), 32'h0);
        chk("t1_lock", 32'(lock), 32'h0);

        // Gap cycles: nothing moves.
        cyc(9'h1EE, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000);
        chk("t6_frm", 32'(frm), 32'h0);
        chk("t6_rdy", 32'(rdy), 32'b1111);
        cyc(9'h1EE, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000);
        chk("t6_y0", 32'(y0), 32'h101);

        // Second aligned SYNC raises LOCK, then a misplaced SYNC drops it.
        cyc(9'h000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1111);
        chk("t2_ackall", 32'(rdy), 32'b0000);
        cyc(9'h111, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0000);
        chk("t2_lock", 32'(lock), 32'h1);
        cyc(9'h112, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000);
        cyc(9'h120, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001);
        chk("t2_serr", 32'(serr), 32'h1);
        chk("t2_unlock", 32'(lock), 32'h0);
        chk("t2_y0", 32'(y0), 32'h120);
        chk("t2_ovf", 32'(ovf), 32'h0);
        cyc(9'h121, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0010);
        chk("t2_realign_y1", 32'(y1), 32'h121);
        chk("t2_serr_pulse", 32'(serr), 32'h0);

        // SEL mode: overrun on channel 2, SYNC ignored.
        cyc(9'h1FF, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000);
        cyc(9'h0AA, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0000);
        chk("t3_y2", 32'(y2), 32'h0AA);
        chk("t3_ovf", 32'(ovf), 32'b0100);
        chk("t3_y0", 32'(y0), 32'h120);
        chk("t3_y1", 32'(y1), 32'h121);
        chk("t3_y3", 32'(y3), 32'h104);
        chk("t3_serr", 32'(serr), 32'h0);
        // Slot counter kept its value (2) across the SEL-mode writes.
        cyc(9'h0C3, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0100);
        chk("t3_slot_kept", 32'(y2), 32'h0C3);

        // Acknowledge and write on channel 1 together: write wins.
        cyc(9'h055, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010);
        chk("t4_y1", 32'(y1), 32'h055);
        chk("t4_rdy1", 32'(rdy[1]), 32'h1);
        chk("t4_ovf", 32'(ovf), 32'b0100);

        // Re-establish LOCK and reach slot 2, then reset asynchronously.
        cyc(9'h130, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1111);
        cyc(9'h140, 1'b1, 1'b1, 1'b1, 2'd0, 4'b1111);
        cyc(9'h141, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1111);
        cyc(9'h142, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1111);
        cyc(9'h143, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1111);
        cyc(9'h150, 1'b1, 1'b1, 1'b1, 2'd0, 4'b1111);
        cyc(9'h151, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1111);
        chk("t5_lock_pre", 32'(lock), 32'h1);
        chk("t5_y1_pre", 32'(y1), 32'h151);
        dv = 1'b0;
        #1 rstn = 1'b0;
        #1;
        chk("t5_y0", 32'(y0), 32'h0);
        chk("t5_y1", 32'(y1), 32'h0);
        chk("t5_rdy", 32'(rdy), 32'h0);
        chk("t5_ovf", 32'(ovf), 32'h0);
        chk("t5_lock", 32'(lock), 32'h0);
        @(posedge clk);
        #2 rstn = 1'b1;
        cyc(9'h1A5, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000);
        chk("t5_first_y0", 32'(y0), 32'h1A5);
        chk("t5_first_rdy", 32'(rdy), 32'b0001);

        cyc(9'h000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000);
        cyc(9'h000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
